// File: rtl/oled_spi_tx.sv
// Byte-wide SPI transmitter for the PmodOLEDrgb pins (cs, sclk, sdin, dc), MSB first.
// Define OLED_SPI_BURST_EN to let back-to-back bytes share one cs frame.
module oled_spi_tx #(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_dc,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       cs,
    output logic       sclk,
    output logic       sdin,
    output logic       dc
);
    localparam int CMAX = (CLK_DIV > CS_SETUP)
                        ? ((CLK_DIV > CS_HOLD) ? CLK_DIV : CS_HOLD)
                        : ((CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD);
    localparam int CW = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam logic [CW-1:0] DIV_LAST   = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(CS_HOLD - 1);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [2:0]    bitn, bitn_d;
    logic [7:0]    shreg, shreg_d;
    logic          cs_d, sclk_d, sdin_d, dc_d;
    logic          last_shift;

    // last cycle of bit 0 high phase: the next edge would be a falling edge
    assign last_shift = (state == SHIFT) && sclk && (cnt == DIV_LAST) && (bitn == 3'd0);

`ifdef OLED_SPI_BURST_EN
    assign tx_ready = (state == IDLE) || last_shift;
`else
    assign tx_ready = (state == IDLE);
`endif
    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            bitn  <= 3'd7;
            shreg <= 8'h00;
            cs    <= 1'b1;
            sclk  <= 1'b1;
            sdin  <= 1'b0;
            dc    <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            bitn  <= bitn_d;
            shreg <= shreg_d;
            cs    <= cs_d;
            sclk  <= sclk_d;
            sdin  <= sdin_d;
            dc    <= dc_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        bitn_d  = bitn;
        shreg_d = shreg;
        cs_d    = cs;
        sclk_d  = sclk;
        sdin_d  = sdin;
        dc_d    = dc;
        case (state)
            IDLE: begin
                if (tx_valid) begin
                    shreg_d = tx_data;
                    dc_d    = tx_dc;
                    sdin_d  = tx_data[7];
                    cs_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (cnt == SETUP_LAST) begin
                    sclk_d  = 1'b0;
                    cnt_d   = '0;
                    bitn_d  = 3'd7;
                    state_d = SHIFT;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            SHIFT: begin
                if (cnt != DIV_LAST) begin
                    cnt_d = cnt + 1'b1;
                end else begin
                    cnt_d  = '0;
                    sclk_d = ~sclk;
                    // end of a high phase: next bit goes out on the falling edge
                    if (sclk) begin
                        if (bitn != 3'd0) begin
                            bitn_d = bitn - 3'd1;
                            sdin_d = shreg[bitn - 3'd1];
                        end else begin
`ifdef OLED_SPI_BURST_EN
                            if (tx_valid) begin
                                shreg_d = tx_data;
                                dc_d    = tx_dc;
                                sdin_d  = tx_data[7];
                                bitn_d  = 3'd7;
                            end else begin
                                sclk_d  = 1'b1;
                                state_d = HOLD;
                            end
`else
                            sclk_d  = 1'b1;
                            state_d = HOLD;
`endif
                        end
                    end
                end
            end
            HOLD: begin
                if (cnt == HOLD_LAST) begin
                    cs_d    = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule
